// File: rtl/wheel_conv_pkg.sv
// Shared constants, state encoding and sign-magnitude helper for the wheel
// conversion scheduler.
package wheel_conv_pkg;

    localparam int N_WHEELS = 4;
    localparam int N_WIDTH  = 17;
    localparam int Q_WIDTH  = 8;
    localparam int RPM_DATA = 8;

    localparam int MAG_W = N_WIDTH - 1;
    localparam int N_OPS = 2 * N_WHEELS;
    localparam int OP_W  = $clog2(N_OPS);

    localparam logic [OP_W-1:0]  OP_LAST   = OP_W'(N_OPS - 1);
    localparam logic [MAG_W-1:0] K_PUL2RPM = 16'h04C5;
    localparam logic [MAG_W-1:0] K_RPM2RAD = 16'h001B;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        WR
    } state_e;

    // A zero magnitude always carries a cleared sign, so negative zero never appears.
    function automatic logic [N_WIDTH-1:0] sm_word(input logic sign, input logic [MAG_W-1:0] mag);
        return {sign & (|mag), mag};
    endfunction

endpackage

// File: rtl/wheel_conv_scheduler_if.sv
// Frame tick, pulse-count inputs and the published rpm / rad/s result buses.
interface wheel_conv_scheduler_if
    import wheel_conv_pkg::*;
;
    logic                         WHEEL_CONV_SCHEDULER_TICK_In;
    logic [N_WHEELS*RPM_DATA-1:0] WHEEL_CONV_SCHEDULER_COUNT_InBus;
    logic [N_WHEELS-1:0]          WHEEL_CONV_SCHEDULER_SIGN_InBus;
    logic [N_WHEELS*N_WIDTH-1:0]  WHEEL_CONV_SCHEDULER_RPM_OutBus;
    logic [N_WHEELS*N_WIDTH-1:0]  WHEEL_CONV_SCHEDULER_W_OutBus;
    logic                         WHEEL_CONV_SCHEDULER_BUSY_Out;
    logic                         WHEEL_CONV_SCHEDULER_DONE_Out;
    logic                         WHEEL_CONV_SCHEDULER_OVR_Out;

    modport master (
        output WHEEL_CONV_SCHEDULER_TICK_In,
        output WHEEL_CONV_SCHEDULER_COUNT_InBus,
        output WHEEL_CONV_SCHEDULER_SIGN_InBus,
        input  WHEEL_CONV_SCHEDULER_RPM_OutBus,
        input  WHEEL_CONV_SCHEDULER_W_OutBus,
        input  WHEEL_CONV_SCHEDULER_BUSY_Out,
        input  WHEEL_CONV_SCHEDULER_DONE_Out,
        input  WHEEL_CONV_SCHEDULER_OVR_Out
    );

    modport slave (
        input  WHEEL_CONV_SCHEDULER_TICK_In,
        input  WHEEL_CONV_SCHEDULER_COUNT_InBus,
        input  WHEEL_CONV_SCHEDULER_SIGN_InBus,
        output WHEEL_CONV_SCHEDULER_RPM_OutBus,
        output WHEEL_CONV_SCHEDULER_W_OutBus,
        output WHEEL_CONV_SCHEDULER_BUSY_Out,
        output WHEEL_CONV_SCHEDULER_DONE_Out,
        output WHEEL_CONV_SCHEDULER_OVR_Out
    );

endinterface

// File: rtl/qmult_sat_reg.sv
// Registered Q8.8 sign-magnitude multiplier: unsigned magnitude product,
// truncated by Q_WIDTH, saturating to all-ones with an overflow flag.
module qmult_sat_reg
    import wheel_conv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [MAG_W-1:0]   a_i,
    input  logic [MAG_W-1:0]   b_i,
    input  logic               sign_i,
    output logic [N_WIDTH-1:0] result_o,
    output logic               ovf_o
);

    logic [2*MAG_W-1:0] prod;
    logic [2*MAG_W-1:0] prod_sh;
    logic [MAG_W-1:0]   mag_d;
    logic               ovf_d;
    logic [N_WIDTH-1:0] result_q;
    logic               ovf_q;

    // Anything left above the 16-bit magnitude after the shift is an overflow.
    always_comb begin
        prod    = {{MAG_W{1'b0}}, a_i} * {{MAG_W{1'b0}}, b_i};
        prod_sh = prod >> Q_WIDTH;
        ovf_d   = |prod_sh[2*MAG_W-1:MAG_W];
        mag_d   = ovf_d ? {MAG_W{1'b1}} : prod_sh[MAG_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else if (load_i) begin
            result_q <= sm_word(sign_i, mag_d);
            ovf_q    <= ovf_d;
        end
    end

    assign result_o = result_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/wheel_conv_scheduler.sv
// Four-wheel conversion sequencer: snapshots pulse counts on a tick, walks them
// through one shared multiplier and publishes a coherent rpm / rad/s set.
module wheel_conv_scheduler
    import wheel_conv_pkg::*;
(
    input  logic                  WHEEL_CONV_SCHEDULER_CLOCK,
    input  logic                  WHEEL_CONV_SCHEDULER_RESET_InHigh,
    wheel_conv_scheduler_if.slave bus
);

    state_e state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [N_WHEELS-1:0][RPM_DATA-1:0] count_snap_q;
    logic [N_WHEELS-1:0]               sign_snap_q;
    logic [N_WHEELS-1:0][N_WIDTH-1:0]  rpm_sh_q, rpm_sh_d;
    logic [N_WHEELS-1:0][N_WIDTH-1:0]  w_sh_q, w_sh_d;
    logic [N_WHEELS-1:0][N_WIDTH-1:0]  rpm_out_q;
    logic [N_WHEELS-1:0][N_WIDTH-1:0]  w_out_q;
    logic frame_ovf_q, frame_ovf_d;
    logic done_q;
    logic ovr_q;
    logic publish;
    logic start;

    logic [OP_W-2:0]    wheel;
    logic               is_rad;
    logic [MAG_W-1:0]   mul_a;
    logic [MAG_W-1:0]   mul_b;
    logic               mul_sign;
    logic [N_WIDTH-1:0] mul_result;
    logic               mul_ovf;

    assign wheel  = op_q[OP_W-1:1];
    assign is_rad = op_q[0];
    assign start  = (state_q == IDLE) && bus.WHEEL_CONV_SCHEDULER_TICK_In;

    // RAD ops reuse the rpm magnitude written by the preceding WR of the same wheel.
    always_comb begin
        mul_a    = is_rad ? rpm_sh_q[wheel][MAG_W-1:0] : {count_snap_q[wheel], {Q_WIDTH{1'b0}}};
        mul_b    = is_rad ? K_RPM2RAD : K_PUL2RPM;
        mul_sign = sign_snap_q[wheel];
    end

    qmult_sat_reg u_mult (
        .clk      (WHEEL_CONV_SCHEDULER_CLOCK),
        .rst      (WHEEL_CONV_SCHEDULER_RESET_InHigh),
        .load_i   (state_q == MUL),
        .a_i      (mul_a),
        .b_i      (mul_b),
        .sign_i   (mul_sign),
        .result_o (mul_result),
        .ovf_o    (mul_ovf)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rpm_sh_d    = rpm_sh_q;
        w_sh_d      = w_sh_q;
        frame_ovf_d = frame_ovf_q;
        publish     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.WHEEL_CONV_SCHEDULER_TICK_In) begin
                    state_d     = MUL;
                    op_d        = '0;
                    frame_ovf_d = 1'b0;
                end
            end
            MUL: begin
                state_d = WR;
            end
            WR: begin
                if (is_rad) begin
                    w_sh_d[wheel] = mul_result;
                end else begin
                    rpm_sh_d[wheel] = mul_result;
                end
                frame_ovf_d = frame_ovf_q | mul_ovf;
                op_d        = op_q + OP_W'(1);
                if (op_q == OP_LAST) begin
                    state_d = IDLE;
                    publish = 1'b1;
                end else begin
                    state_d = MUL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The last op's result is taken from the next-state shadows so it lands in the same publish.
    always_ff @(posedge WHEEL_CONV_SCHEDULER_CLOCK or posedge WHEEL_CONV_SCHEDULER_RESET_InHigh) begin
        if (WHEEL_CONV_SCHEDULER_RESET_InHigh) begin
            state_q      <= IDLE;
            op_q         <= '0;
            count_snap_q <= '0;
            sign_snap_q  <= '0;
            rpm_sh_q     <= '0;
            w_sh_q       <= '0;
            rpm_out_q    <= '0;
            w_out_q      <= '0;
            frame_ovf_q  <= 1'b0;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rpm_sh_q    <= rpm_sh_d;
            w_sh_q      <= w_sh_d;
            frame_ovf_q <= frame_ovf_d;
            done_q      <= publish;
            if (start) begin
                count_snap_q <= bus.WHEEL_CONV_SCHEDULER_COUNT_InBus;
                sign_snap_q  <= bus.WHEEL_CONV_SCHEDULER_SIGN_InBus;
            end
            if (publish) begin
                rpm_out_q <= rpm_sh_d;
                w_out_q   <= w_sh_d;
                ovr_q     <= frame_ovf_d;
            end
        end
    end

    assign bus.WHEEL_CONV_SCHEDULER_RPM_OutBus = rpm_out_q;
    assign bus.WHEEL_CONV_SCHEDULER_W_OutBus   = w_out_q;
    assign bus.WHEEL_CONV_SCHEDULER_BUSY_Out   = (state_q != IDLE);
    assign bus.WHEEL_CONV_SCHEDULER_DONE_Out   = done_q;
    assign bus.WHEEL_CONV_SCHEDULER_OVR_Out    = ovr_q;

endmodule

// File: tb/tb_wheel_conv_scheduler.sv
// Directed bench for wheel_conv_scheduler: hand-computed rpm / rad/s words,
// saturation, frame timing, tick rejection while busy and mid-frame reset.
module tb_wheel_conv_scheduler;
    import wheel_conv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   doneCount = 0;

    always #5 clk = ~clk;

    wheel_conv_scheduler_if bus ();

    wheel_conv_scheduler dut (
        .WHEEL_CONV_SCHEDULER_CLOCK        (clk),
        .WHEEL_CONV_SCHEDULER_RESET_InHigh (rst),
        .bus                               (bus)
    );

    logic [67:0] rpmOut;
    logic [67:0] wOut;
    logic        busyOut;
    logic        doneOut;
    logic        ovrOut;

    assign rpmOut  = bus.WHEEL_CONV_SCHEDULER_RPM_OutBus;
    assign wOut    = bus.WHEEL_CONV_SCHEDULER_W_OutBus;
    assign busyOut = bus.WHEEL_CONV_SCHEDULER_BUSY_Out;
    assign doneOut = bus.WHEEL_CONV_SCHEDULER_DONE_Out;
    assign ovrOut  = bus.WHEEL_CONV_SCHEDULER_OVR_Out;

    always @(negedge clk) begin
        if (doneOut === 1'b1) doneCount++;
    end

    // Pulses TICK for one edge, then counts negedges until DONE (40 means it never came).
    task automatic run_frame(input logic [31:0] counts, input logic [3:0] signs, output int lat);
        bus.WHEEL_CONV_SCHEDULER_COUNT_InBus = counts;
        bus.WHEEL_CONV_SCHEDULER_SIGN_InBus  = signs;
        bus.WHEEL_CONV_SCHEDULER_TICK_In     = 1'b1;
        @(negedge clk);
        bus.WHEEL_CONV_SCHEDULER_TICK_In = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (doneOut === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total += 5;
        if (rpmOut !== 68'h0) begin bad++; $display("[TB] FAIL reset_rpm: got %h expected 0", rpmOut); end
        if (wOut !== 68'h0) begin bad++; $display("[TB] FAIL reset_w: got %h expected 0", wOut); end
        if (busyOut !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busyOut); end
        if (doneOut !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", doneOut); end
        if (ovrOut !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovr: got %b expected 0", ovrOut); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_wheel();
        int lat;
        int base;
        base = doneCount;
        run_frame(32'h0000_000A, 4'b0000, lat);
        total += 5;
        if (lat !== 16) begin bad++; $display("[TB] FAIL single_latency: got %0d expected 16", lat); end
        if (rpmOut !== {17'h0, 17'h0, 17'h0, 17'h02FB2}) begin bad++; $display("[TB] FAIL single_rpm: got %h expected w0=02fb2", rpmOut); end
        if (wOut !== {17'h0, 17'h0, 17'h0, 17'h00507}) begin bad++; $display("[TB] FAIL single_w: got %h expected w0=00507", wOut); end
        if (ovrOut !== 1'b0) begin bad++; $display("[TB] FAIL single_ovr: got %b expected 0", ovrOut); end
        if (busyOut !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_end: got %b expected 0", busyOut); end
        repeat (3) @(negedge clk);
        total++;
        if (doneCount - base !== 1) begin bad++; $display("[TB] FAIL single_done_pulses: got %0d expected 1", doneCount - base); end
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        int base;
        bus.WHEEL_CONV_SCHEDULER_COUNT_InBus = 32'h0000_0014;
        bus.WHEEL_CONV_SCHEDULER_SIGN_InBus  = 4'b0001;
        bus.WHEEL_CONV_SCHEDULER_TICK_In     = 1'b1;
        @(negedge clk);
        bus.WHEEL_CONV_SCHEDULER_TICK_In = 1'b0;
        base = doneCount;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total += 4;
        if (rpmOut !== 68'h0) begin bad++; $display("[TB] FAIL midreset_rpm: got %h expected 0", rpmOut); end
        if (wOut !== 68'h0) begin bad++; $display("[TB] FAIL midreset_w: got %h expected 0", wOut); end
        if (busyOut !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy: got %b expected 0", busyOut); end
        if (ovrOut !== 1'b0) begin bad++; $display("[TB] FAIL midreset_ovr: got %b expected 0", ovrOut); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        total += 2;
        if (doneCount - base !== 0) begin bad++; $display("[TB] FAIL midreset_done_pulses: got %0d expected 0", doneCount - base); end
        if (rpmOut !== 68'h0) begin bad++; $display("[TB] FAIL midreset_rpm_later: got %h expected 0", rpmOut); end
        run_frame(32'h0000_000A, 4'b0000, lat);
        total += 2;
        if (lat !== 16) begin bad++; $display("[TB] FAIL midreset_next_latency: got %0d expected 16", lat); end
        if (rpmOut !== {17'h0, 17'h0, 17'h0, 17'h02FB2}) begin bad++; $display("[TB] FAIL midreset_next_rpm: got %h expected w0=02fb2", rpmOut); end
    endtask

    task automatic test_saturation();
        int lat;
        run_frame(32'h0035_0000, 4'b0100, lat);
        total += 3;
        if (rpmOut !== {17'h0, 17'h1FCC9, 17'h0, 17'h0}) begin bad++; $display("[TB] FAIL sat53_rpm: got %h expected w2=1fcc9", rpmOut); end
        if (wOut !== {17'h0, 17'h11AA9, 17'h0, 17'h0}) begin bad++; $display("[TB] FAIL sat53_w: got %h expected w2=11aa9", wOut); end
        if (ovrOut !== 1'b0) begin bad++; $display("[TB] FAIL sat53_ovr: got %b expected 0", ovrOut); end
        run_frame(32'h0036_0000, 4'b0100, lat);
        total += 3;
        if (rpmOut !== {17'h0, 17'h1FFFF, 17'h0, 17'h0}) begin bad++; $display("[TB] FAIL sat54_rpm: got %h expected w2=1ffff", rpmOut); end
        if (wOut !== {17'h0, 17'h11AFF, 17'h0, 17'h0}) begin bad++; $display("[TB] FAIL sat54_w: got %h expected w2=11aff", wOut); end
        if (ovrOut !== 1'b1) begin bad++; $display("[TB] FAIL sat54_ovr: got %b expected 1", ovrOut); end
    endtask

    task automatic test_zero_sign();
        int lat;
        run_frame(32'h0000_0000, 4'b1111, lat);
        total += 3;
        if (rpmOut !== 68'h0) begin bad++; $display("[TB] FAIL zero_rpm: got %h expected 0", rpmOut); end
        if (wOut !== 68'h0) begin bad++; $display("[TB] FAIL zero_w: got %h expected 0", wOut); end
        if (ovrOut !== 1'b0) begin bad++; $display("[TB] FAIL zero_ovr_cleared: got %b expected 0", ovrOut); end
    endtask

    // TICKs at k+5 and k+16 must be dropped; the one at k+17 publishes at k+33.
    task automatic test_back_to_back();
        int lat;
        int base;
        bus.WHEEL_CONV_SCHEDULER_COUNT_InBus = 32'h0000_0A00;
        bus.WHEEL_CONV_SCHEDULER_SIGN_InBus  = 4'b0000;
        bus.WHEEL_CONV_SCHEDULER_TICK_In     = 1'b1;
        @(negedge clk);
        base = doneCount;
        for (int m = 1; m <= 16; m++) begin
            bus.WHEEL_CONV_SCHEDULER_TICK_In = (m == 5 || m == 16);
            @(negedge clk);
            if (m == 5) begin
                total++;
                if (busyOut !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy: got %b expected 1", busyOut); end
            end
            if (m == 15) begin
                total += 2;
                if (rpmOut !== 68'h0) begin bad++; $display("[TB] FAIL b2b_hold_rpm: got %h expected 0", rpmOut); end
                if (doneOut !== 1'b0) begin bad++; $display("[TB] FAIL b2b_early_done: got %b expected 0", doneOut); end
            end
            if (m == 16) begin
                total += 2;
                if (doneOut !== 1'b1) begin bad++; $display("[TB] FAIL b2b_done_k16: got %b expected 1", doneOut); end
                if (rpmOut !== {17'h0, 17'h0, 17'h02FB2, 17'h0}) begin bad++; $display("[TB] FAIL b2b_rpm: got %h expected w1=02fb2", rpmOut); end
            end
        end
        run_frame(32'h0500_0000, 4'b1000, lat);
        total += 4;
        if (lat !== 16) begin bad++; $display("[TB] FAIL b2b_next_latency: got %0d expected 16", lat); end
        if (rpmOut !== {17'h117D9, 17'h0, 17'h0, 17'h0}) begin bad++; $display("[TB] FAIL b2b_next_rpm: got %h expected w3=117d9", rpmOut); end
        if (wOut !== {17'h10283, 17'h0, 17'h0, 17'h0}) begin bad++; $display("[TB] FAIL b2b_next_w: got %h expected w3=10283", wOut); end
        repeat (3) @(negedge clk);
        if (doneCount - base !== 2) begin bad++; $display("[TB] FAIL b2b_done_pulses: got %0d expected 2", doneCount - base); end
        total++;
    endtask

    task automatic test_input_change();
        int lat;
        bus.WHEEL_CONV_SCHEDULER_COUNT_InBus = 32'h0000_000A;
        bus.WHEEL_CONV_SCHEDULER_SIGN_InBus  = 4'b0000;
        bus.WHEEL_CONV_SCHEDULER_TICK_In     = 1'b1;
        @(negedge clk);
        bus.WHEEL_CONV_SCHEDULER_TICK_In     = 1'b0;
        bus.WHEEL_CONV_SCHEDULER_COUNT_InBus = 32'hFFFF_FFFF;
        bus.WHEEL_CONV_SCHEDULER_SIGN_InBus  = 4'b1111;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (doneOut === 1'b1) break;
        end
        total += 4;
        if (lat !== 16) begin bad++; $display("[TB] FAIL snap_latency: got %0d expected 16", lat); end
        if (rpmOut !== {17'h0, 17'h0, 17'h0, 17'h02FB2}) begin bad++; $display("[TB] FAIL snap_rpm: got %h expected w0=02fb2", rpmOut); end
        if (wOut !== {17'h0, 17'h0, 17'h0, 17'h00507}) begin bad++; $display("[TB] FAIL snap_w: got %h expected w0=00507", wOut); end
        if (ovrOut !== 1'b0) begin bad++; $display("[TB] FAIL snap_ovr: got %b expected 0", ovrOut); end
        bus.WHEEL_CONV_SCHEDULER_COUNT_InBus = 32'h0;
        bus.WHEEL_CONV_SCHEDULER_SIGN_InBus  = 4'b0000;
    endtask

    initial begin
        bus.WHEEL_CONV_SCHEDULER_TICK_In     = 1'b0;
        bus.WHEEL_CONV_SCHEDULER_COUNT_InBus = 32'h0;
        bus.WHEEL_CONV_SCHEDULER_SIGN_InBus  = 4'b0000;
        test_reset();
        test_single_wheel();
        test_reset_mid_frame();
        test_saturation();
        test_zero_sign();
        test_back_to_back();
        test_input_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
